// File: rtl/unified_mem_arbiter.sv
// Round-robin arbiter with burst locking for the shared byte-wide memory port.
// Requesters: 0 = instruction fetch, 1 = load unit, 2 = store unit.
// Returned read data is routed to whichever requester issued the read, using a
// fixed-latency tag pipeline, so data lands correctly after ownership moves on.
//
// Handshake: a requester holds req_i high for its whole burst. Once gnt_o is
// high, every cycle with req_i high is one memory access, issued combinationally
// from that requester's we/addr/wdata slices. Dropping req_i ends the burst; the
// port goes idle for one cycle before the next owner is granted. Read data for an
// access issued in cycle t appears on rdata_o with rvalid_o[id] in cycle
// t + MEM_LATENCY. busy_o exposes the FSM state (1 = OWNED).
module unified_mem_arbiter #(
    parameter int ADDR_WIDTH  = 24,
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_REQ     = 3,
    parameter int MEM_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0]            we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic [NUM_REQ-1:0]            rvalid_o,
    output logic                          mem_req_o,
    output logic                          mem_we_o,
    output logic [ADDR_WIDTH-1:0]         mem_addr_o,
    output logic [DATA_WIDTH-1:0]         mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]         mem_rdata_i,
    output logic                          busy_o
);

    localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [OWN_W-1:0] owner_q;
    logic [OWN_W-1:0] rr_ptr_q;
    logic [OWN_W-1:0] pick;
    logic [OWN_W-1:0] next_ptr;
    logic             owner_req;
    logic             issue_rd;

    // Read tag pipeline: stage 0 is loaded at issue, the last stage is the tail.
    logic             rd_v_q  [MEM_LATENCY];
    logic [OWN_W-1:0] rd_id_q [MEM_LATENCY];

    // First set request at or after ptr, wrapping around.
    function automatic logic [OWN_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [OWN_W-1:0]   ptr);
        logic [OWN_W-1:0] idx;
        logic             found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = OWN_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    assign pick      = rr_pick(req_i, rr_ptr_q);
    assign owner_req = req_i[owner_q];
    assign next_ptr  = (owner_q == OWN_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign issue_rd  = mem_req_o & ~mem_we_o;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: grab the port on any request, release it when the owner drops.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req_i)     state_d = OWNED;
            OWNED:   if (!owner_req) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Owner capture on grant; round-robin pointer advances past the owner on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            if (state_q == IDLE && (|req_i))       owner_q  <= pick;
            if (state_q == OWNED && !owner_req)    rr_ptr_q <= next_ptr;
        end
    end

    // Outputs: grant to the owner, memory port driven from the owner's slices while it requests.
    always_comb begin
        gnt_o       = '0;
        busy_o      = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (state_q == OWNED) begin
            gnt_o[owner_q] = 1'b1;
            busy_o         = 1'b1;
            if (owner_req) begin
                mem_req_o   = 1'b1;
                mem_we_o    = we_i[owner_q];
                mem_addr_o  = addr_i[int'(owner_q) * ADDR_WIDTH +: ADDR_WIDTH];
                mem_wdata_o = wdata_i[int'(owner_q) * DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Shift read tags toward the tail, one stage per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                rd_v_q[i]  <= 1'b0;
                rd_id_q[i] <= '0;
            end
        end else begin
            rd_v_q[0]  <= issue_rd;
            rd_id_q[0] <= owner_q;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                rd_v_q[i]  <= rd_v_q[i-1];
                rd_id_q[i] <= rd_id_q[i-1];
            end
        end
    end

    // Tail of the tag pipeline steers the returned byte to its issuer.
    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        if (rd_v_q[MEM_LATENCY-1]) begin
            rvalid_o[rd_id_q[MEM_LATENCY-1]] = 1'b1;
            rdata_o                          = mem_rdata_i;
        end
    end

endmodule
